bcd_score_accum: RTL and testbench

Parametrised multi-digit packed-BCD accumulator holding the running game score. On each accepted request it adds a BCD addend to the stored score one decimal digit per clock, rippling the decimal carry between cycles, then commits the result with either saturation or wrap-around on overflow. It sits between the line-clear scoring logic, which issues addends, and the seven-segment score display, which reads `score` directly.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_score_accum.sv | 148 ++++++++++++++
 tb/tb_bcd_score_accum.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants, accumulator state encoding and digit clamp helper.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;
    localparam logic [BCD_DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADD    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [BCD_DIGIT_W-1:0] bcd_clamp(input logic [BCD_DIGIT_W-1:0] d);
        return (d > BCD_NINE) ? BCD_NINE : d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: binary sum with +6 decimal correction and carry-out.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] s,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
        s    = raw[BCD_DIGIT_W-1:0];
        cout = 1'b0;
        // Sums 10..19 wrap back into 0..9 once 6 is added modulo 16.
        if (raw > {1'b0, BCD_NINE}) begin
            s    = raw[BCD_DIGIT_W-1:0] + BCD_CORR;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_score_accum.sv
// Multi-digit packed-BCD score accumulator: one digit per clock, then a commit
// cycle that either saturates to all-nines or wraps on overflow.
module bcd_score_accum
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS   = 6,
    parameter int unsigned SATURATE = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] addend,
    input  logic                          clear,
    output logic [BCD_DIGIT_W*DIGITS-1:0] score,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    localparam int unsigned W     = BCD_DIGIT_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     operand_q, operand_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     score_q, score_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic [BCD_DIGIT_W-1:0] dig_a, dig_b, dig_s;
    logic                   dig_cout;

    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dig_a = score_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
                dig_b = operand_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
            end
        end
    end

    bcd_digit_add u_digit_add (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_cout)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        operand_d  = operand_q;
        work_d     = work_q;
        score_d    = score_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        if (clear) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            carry_d    = 1'b0;
            score_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < DIGITS; i++) begin
                            operand_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
                                bcd_clamp(addend[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
                        end
                        work_d  = score_q;
                        idx_d   = '0;
                        carry_d = 1'b0;
                        state_d = ST_ADD;
                    end
                end
                ST_ADD: begin
                    for (int unsigned i = 0; i < DIGITS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            work_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dig_s;
                        end
                    end
                    carry_d = dig_cout;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_COMMIT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_COMMIT: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    score_d = work_q;
                    if (carry_q) begin
                        overflow_d = 1'b1;
                        if (SATURATE != 0) begin
                            for (int unsigned i = 0; i < DIGITS; i++) begin
                                score_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_NINE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            operand_q  <= '0;
            work_q     <= '0;
            score_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            operand_q  <= operand_d;
            work_q     <= work_d;
            score_q    <= score_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        score    = score_q;
        busy     = (state_q != ST_IDLE);
        done     = done_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_bcd_score_accum.sv
// Directed bench for bcd_score_accum: saturating and wrapping instances share
// stimulus; expected {overflow, score} pairs are queued and checked on done.
module tb_bcd_score_accum;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         reset, start, clear;
    logic [W-1:0] addend;
    logic [W-1:0] score_s, score_w;
    logic         busy_s, busy_w, done_s, done_w, overflow_s, overflow_w;

    int tests = 0;
    int fails = 0;
    int done_cnt_s = 0;
    int done_cnt_w = 0;

    logic [W:0] q_s[$];
    logic [W:0] q_w[$];
    logic [W:0] e_s, e_w;

    bcd_score_accum #(.DIGITS(DIGITS), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .addend(addend), .clear(clear),
        .score(score_s), .busy(busy_s), .done(done_s), .overflow(overflow_s)
    );

    bcd_score_accum #(.DIGITS(DIGITS), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .addend(addend), .clear(clear),
        .score(score_w), .busy(busy_w), .done(done_w), .overflow(overflow_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    // Scoreboard: every done pulse consumes one expected {overflow, score}.
    always @(negedge clk) begin
        if (done_s) begin
            done_cnt_s++;
            check("sat_expected_pending", 32'(q_s.size() > 0), 32'd1);
            if (q_s.size() > 0) begin
                e_s = q_s.pop_front();
                check("sat_score", 32'(score_s), 32'(e_s[W-1:0]));
                check("sat_overflow", 32'(overflow_s), 32'(e_s[W]));
            end
        end
        if (done_w) begin
            done_cnt_w++;
            check("wrap_expected_pending", 32'(q_w.size() > 0), 32'd1);
            if (q_w.size() > 0) begin
                e_w = q_w.pop_front();
                check("wrap_score", 32'(score_w), 32'(e_w[W-1:0]));
                check("wrap_overflow", 32'(overflow_w), 32'(e_w[W]));
            end
        end
    end

    task automatic do_add(input logic [W-1:0] a, input logic [W:0] exp_s, input logic [W:0] exp_w);
        int   n;
        logic busy_ok;
        @(negedge clk);
        start  = 1'b1;
        addend = a;
        q_s.push_back(exp_s);
        q_w.push_back(exp_w);
        @(negedge clk);
        start   = 1'b0;
        addend  = '0;
        n       = 0;
        busy_ok = 1'b1;
        while (!done_s && n < 20) begin
            busy_ok = busy_ok & busy_s & busy_w;
            @(negedge clk);
            n++;
        end
        check("done_latency", 32'(n), 32'd5);
        check("busy_during_add", 32'(busy_ok), 32'd1);
        check("busy_low_with_done", 32'({busy_s, busy_w}), 32'd0);
        check("done_both", 32'({done_s, done_w}), 32'd3);
        @(negedge clk);
        check("done_single_cycle", 32'({done_s, done_w}), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_score"}, 32'({score_s, score_w}), 32'd0);
        check({tag, "_busy"}, 32'({busy_s, busy_w}), 32'd0);
        check({tag, "_overflow"}, 32'({overflow_s, overflow_w}), 32'd0);
    endtask

    initial begin
        int c_s, c_w;
        reset  = 1'b1;
        start  = 1'b0;
        clear  = 1'b0;
        addend = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_cleared("reset");
        check("reset_done", 32'({done_s, done_w}), 32'd0);

        // Carry ripple across three digits.
        do_add(16'h0999, 17'h0_0999, 17'h0_0999);
        do_add(16'h0001, 17'h0_1000, 17'h0_1000);
        check("ripple_no_overflow", 32'({overflow_s, overflow_w}), 32'd0);

        // Overflow: saturate vs wrap, then sticky behaviour.
        do_add(16'h8998, 17'h0_9998, 17'h0_9998);
        do_add(16'h0005, 17'h1_9999, 17'h1_0003);
        do_add(16'h0001, 17'h1_9999, 17'h1_0004);

        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check_cleared("clear_idle");

        // Invalid digit A clamps to 9.
        do_add(16'h00A3, 17'h0_0093, 17'h0_0093);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;

        // Start while busy is ignored.
        c_s = done_cnt_s;
        c_w = done_cnt_w;
        @(negedge clk);
        start  = 1'b1;
        addend = 16'h0010;
        q_s.push_back(17'h0_0010);
        q_w.push_back(17'h0_0010);
        @(negedge clk); start = 1'b0; addend = '0;
        repeat (2) @(negedge clk);
        start  = 1'b1;
        addend = 16'h0001;
        @(negedge clk); start = 1'b0; addend = '0;
        repeat (12) @(negedge clk);
        check("busy_start_done_count", 32'(done_cnt_s - c_s), 32'd1);
        check("busy_start_done_count_w", 32'(done_cnt_w - c_w), 32'd1);
        check("busy_start_score", 32'({score_s, score_w}), 32'h0010_0010);

        // Clear during ADD aborts without done.
        c_s = done_cnt_s;
        @(negedge clk); start = 1'b1; addend = 16'h0005;
        @(negedge clk); start = 1'b0; addend = '0;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check_cleared("clear_mid_add");
        repeat (8) @(negedge clk);
        check("clear_mid_add_no_done", 32'(done_cnt_s - c_s), 32'd0);
        do_add(16'h0042, 17'h0_0042, 17'h0_0042);

        // Set overflow, then reset during ADD.
        do_add(16'h9999, 17'h1_9999, 17'h1_0041);
        c_s = done_cnt_s;
        @(negedge clk); start = 1'b1; addend = 16'h0001;
        @(negedge clk); start = 1'b0; addend = '0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_cleared("reset_mid_add");
        repeat (8) @(negedge clk);
        check("reset_mid_add_no_done", 32'(done_cnt_s - c_s), 32'd0);
        do_add(16'h0042, 17'h0_0042, 17'h0_0042);

        repeat (2) @(negedge clk);
        check("sat_queue_drained", 32'(q_s.size()), 32'd0);
        check("wrap_queue_drained", 32'(q_w.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
